// File: rtl/serial_adder_if.sv
// Request/result bundle for the bit-serial adder/subtractor.
// The master side drives operands and start; the slave side (the adder)
// returns busy/done and the held result.
interface serial_adder_if #(
  parameter int WIDTH = 8
) ();
  logic             start;
  logic             sub;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output start, sub, cin, a, b,
    input  busy, done, sum, cout, overflow
  );

  modport slave (
    input  start, sub, cin, a, b,
    output busy, done, sum, cout, overflow
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: operands are captured on start and summed
// LSB-first through one full-adder slice with a registered carry. Result,
// carry-out and signed overflow are published with a one-cycle done pulse
// and held until the next completion.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_adder_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;      // working operand A, shifted right each RUN cycle
  logic [WIDTH-1:0] r_b;      // working operand B (already inverted for subtract)
  logic [WIDTH-1:0] r_s;      // working sum, filled from the MSB end
  logic             r_c;      // running carry
  logic [CNT_W-1:0] r_cnt;    // bit position being processed
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic             w_s;
  logic             w_c_next;
  logic             w_last;

  // Full-adder slice on the current LSBs and the registered carry.
  assign w_s      = r_a[0] ^ r_b[0] ^ r_c;
  assign w_c_next = (r_a[0] & r_b[0]) | (r_a[0] & r_c) | (r_b[0] & r_c);
  assign w_last   = (r_cnt == LAST_CNT);

  // Control FSM and datapath: capture, serial accumulate, publish result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= {WIDTH{1'b0}};
      r_b     <= {WIDTH{1'b0}};
      r_s     <= {WIDTH{1'b0}};
      r_c     <= 1'b0;
      r_cnt   <= {CNT_W{1'b0}};
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sum   <= {WIDTH{1'b0}};
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            // Subtract is a + ~b + 1: invert B and force the carry-in.
            r_a     <= bus.a;
            r_b     <= bus.sub ? ~bus.b : bus.b;
            r_c     <= bus.sub | bus.cin;
            r_s     <= {WIDTH{1'b0}};
            r_cnt   <= {CNT_W{1'b0}};
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_s   <= {w_s, r_s[WIDTH-1:1]};
          r_c   <= w_c_next;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            // r_c here is the carry into the MSB; w_c_next is the carry out.
            r_sum   <= {w_s, r_s[WIDTH-1:1]};
            r_cout  <= w_c_next;
            r_ovf   <= r_c ^ w_c_next;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_state <= S_RUN;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.sum      = r_sum;
  assign bus.cout     = r_cout;
  assign bus.overflow = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed WIDTH=8 scenarios followed
// by a random sweep over WIDTH = 2, 8, 16 and 32 against an arithmetic model.
module tb_serial_adder;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic [7:0] prev8;

  serial_adder_if #(.WIDTH(2))  if2  ();
  serial_adder_if #(.WIDTH(8))  if8  ();
  serial_adder_if #(.WIDTH(16)) if16 ();
  serial_adder_if #(.WIDTH(32)) if32 ();

  serial_adder #(.WIDTH(2))  u_w2  (.clk(clk), .rst_n(rst_n), .bus(if2));
  serial_adder #(.WIDTH(8))  u_w8  (.clk(clk), .rst_n(rst_n), .bus(if8));
  serial_adder #(.WIDTH(16)) u_w16 (.clk(clk), .rst_n(rst_n), .bus(if16));
  serial_adder #(.WIDTH(32)) u_w32 (.clk(clk), .rst_n(rst_n), .bus(if32));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: signed/unsigned integer arithmetic on the operand values.
  function automatic logic [65:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                        input logic cin, input logic sub);
    longint unsigned m, ua, ub, t;
    longint          sa, sb, sr, half;
    logic            co, ov;
    m    = 64'd1 << w;
    ua   = a & (m - 64'd1);
    ub   = b & (m - 64'd1);
    half = longint'(m >> 1);
    sa   = (ua >= (m >> 1)) ? longint'(ua) - longint'(m) : longint'(ua);
    sb   = (ub >= (m >> 1)) ? longint'(ub) - longint'(m) : longint'(ub);
    if (sub) begin
      t  = (ua - ub) & (m - 64'd1);
      co = (ua >= ub);
      sr = sa - sb;
    end else begin
      t  = ua + ub + 64'(cin);
      co = (t >= m);
      t  = t & (m - 64'd1);
      sr = sa + sb + longint'(64'(cin));
    end
    ov = (sr < -half) || (sr > half - 1);
    return {ov, co, t};
  endfunction

  // One WIDTH=8 operation with expected results given as constants.
  task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub,
                         input logic [7:0] es, input logic ec, input logic eo,
                         input bit preloaded, input bit glitch, input bit chain);
    if (!preloaded) begin
      @(negedge clk);
      if8.a = a; if8.b = b; if8.cin = cin; if8.sub = sub; if8.start = 1'b1;
    end
    @(posedge clk);
    #1;
    if (chain) begin
      if8.a = 8'h10; if8.b = 8'h20; if8.cin = 1'b0; if8.sub = 1'b0; if8.start = 1'b1;
    end else begin
      if8.start = 1'b0;
      if8.a = 8'($urandom); if8.b = 8'($urandom);
      if8.cin = 1'($urandom); if8.sub = 1'($urandom);
    end
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk("busy_run", 64'(if8.busy), 64'd1);
      chk("done_early", 64'(if8.done), 64'd0);
      chk("sum_held", 64'(if8.sum), 64'(prev8));
      if (glitch && i == 4) begin
        if8.start = 1'b1; if8.a = 8'hAA; if8.b = 8'h55;
      end
      if (glitch && i == 5) if8.start = 1'b0;
    end
    @(negedge clk);
    chk("done_pulse", 64'(if8.done), 64'd1);
    chk("busy_at_done", 64'(if8.busy), 64'd0);
    chk("sum", 64'(if8.sum), 64'(es));
    chk("cout", 64'(if8.cout), 64'(ec));
    chk("overflow", 64'(if8.overflow), 64'(eo));
    prev8 = es;
    if (!chain) begin
      @(negedge clk);
      chk("done_one_cycle", 64'(if8.done), 64'd0);
      chk("idle_not_busy", 64'(if8.busy), 64'd0);
    end
  endtask

  initial begin
    int          ws [4];
    logic [63:0] va, vb, os, exp_o;
    logic        vc, vs, oc, oo, od, ob;
    logic [65:0] mres;

    ws = '{2, 8, 16, 32};
    total = 0; bad = 0; prev8 = 8'h00;
    if2.start = 1'b0;  if2.sub = 1'b0;  if2.cin = 1'b0;  if2.a = '0;  if2.b = '0;
    if16.start = 1'b0; if16.sub = 1'b0; if16.cin = 1'b0; if16.a = '0; if16.b = '0;
    if32.start = 1'b0; if32.sub = 1'b0; if32.cin = 1'b0; if32.a = '0; if32.b = '0;

    // Reset held with start asserted: outputs stay cleared.
    rst_n = 1'b0;
    if8.a = 8'h3C; if8.b = 8'h05; if8.cin = 1'b0; if8.sub = 1'b0; if8.start = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(if8.busy), 64'd0);
    chk("rst_done", 64'(if8.done), 64'd0);
    chk("rst_sum", 64'(if8.sum), 64'd0);
    chk("rst_cout", 64'(if8.cout), 64'd0);
    chk("rst_ovf", 64'(if8.overflow), 64'd0);
    rst_n = 1'b1;

    // First start after release is accepted: 0x3C + 0x05.
    run_op8(8'h3C, 8'h05, 1'b0, 1'b0, 8'h41, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    // Carry out without signed overflow, then signed overflow.
    run_op8(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op8(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    // Subtract: borrow, then signed overflow; cin is ignored.
    run_op8(8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op8(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    // start pulsed mid-RUN is ignored.
    run_op8(8'h3C, 8'h05, 1'b0, 1'b0, 8'h41, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    // Back-to-back: start held through DONE with 0x10 + 0x20.
    run_op8(8'h22, 8'h11, 1'b1, 1'b0, 8'h34, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    run_op8(8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Reset in the 4th RUN cycle: everything clears and no done follows.
    @(negedge clk);
    if8.a = 8'h12; if8.b = 8'h34; if8.cin = 1'b0; if8.sub = 1'b0; if8.start = 1'b1;
    @(posedge clk);
    #1 if8.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_busy", 64'(if8.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(if8.busy), 64'd0);
    chk("mid_rst_done", 64'(if8.done), 64'd0);
    chk("mid_rst_sum", 64'(if8.sum), 64'd0);
    chk("mid_rst_cout", 64'(if8.cout), 64'd0);
    chk("mid_rst_ovf", 64'(if8.overflow), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("no_done_after_rst", 64'(if8.done), 64'd0);
    end
    chk("sum_after_rst", 64'(if8.sum), 64'd0);

    // Random sweep over all widths, run side by side.
    for (int v = 0; v < 24; v++) begin
      va = {$urandom, $urandom};
      vb = {$urandom, $urandom};
      vc = 1'($urandom);
      vs = 1'($urandom);
      if (v == 0) begin va = '1; vb = '1; vc = 1'b1; vs = 1'b0; end
      if (v == 1) begin va = 64'h8000_0000_8000_8082; vb = 64'd1; vc = 1'b0; vs = 1'b1; end
      @(negedge clk);
      if2.a  = va[1:0];  if2.b  = vb[1:0];  if2.cin  = vc; if2.sub  = vs; if2.start  = 1'b1;
      if8.a  = va[7:0];  if8.b  = vb[7:0];  if8.cin  = vc; if8.sub  = vs; if8.start  = 1'b1;
      if16.a = va[15:0]; if16.b = vb[15:0]; if16.cin = vc; if16.sub = vs; if16.start = 1'b1;
      if32.a = va[31:0]; if32.b = vb[31:0]; if32.cin = vc; if32.sub = vs; if32.start = 1'b1;
      @(posedge clk);
      #1;
      if2.start = 1'b0; if8.start = 1'b0; if16.start = 1'b0; if32.start = 1'b0;
      if2.a = ~if2.a; if8.b = ~if8.b; if16.a = ~if16.a; if32.b = ~if32.b;
      for (int i = 1; i <= 33; i++) begin
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
          case (k)
            0: begin os = 64'(if2.sum);  oc = if2.cout;  oo = if2.overflow;  od = if2.done;  ob = if2.busy;  end
            1: begin os = 64'(if8.sum);  oc = if8.cout;  oo = if8.overflow;  od = if8.done;  ob = if8.busy;  end
            2: begin os = 64'(if16.sum); oc = if16.cout; oo = if16.overflow; od = if16.done; ob = if16.busy; end
            default: begin os = 64'(if32.sum); oc = if32.cout; oo = if32.overflow; od = if32.done; ob = if32.busy; end
          endcase
          if (i == ws[k]) begin
            chk($sformatf("w%0d_busy_last", ws[k]), 64'(ob), 64'd1);
            chk($sformatf("w%0d_done_early", ws[k]), 64'(od), 64'd0);
          end
          if (i == ws[k] + 1) begin
            mres  = model(ws[k], va, vb, vc, vs);
            exp_o = mres[63:0];
            chk($sformatf("w%0d_done", ws[k]), 64'(od), 64'd1);
            chk($sformatf("w%0d_sum", ws[k]), os, exp_o);
            chk($sformatf("w%0d_cout", ws[k]), 64'(oc), 64'(mres[64]));
            chk($sformatf("w%0d_ovf", ws[k]), 64'(oo), 64'(mres[65]));
          end
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
